// File: rtl/machine_timer_unit.sv
// machine_timer_unit: 64-bit mtime counter, mtimecmp comparator and msip bit
// behind a single-outstanding req/ack bus slave. Drives mip.mtip / mip.msip.
// Ports: CLK/RST (sync, active-high); ren/wen/addr/byte_en/wdata request in;
//        rdata/ack/error completion out (ack one cycle after accept);
//        mtime_o, timer_int, soft_int status out.
module machine_timer_unit #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FFE0,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] addr,
  input  logic [3:0]  byte_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        error,
  output logic [63:0] mtime_o,
  output logic        timer_int,
  output logic        soft_int
);

  localparam logic [15:0] PCOUNT_LAST = 16'(PRESCALE - 1);

  typedef enum logic {
    ST_IDLE,
    ST_ACK
  } state_t;

  state_t      state;
  logic [15:0] pcount;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;

  logic        tick;
  logic        in_window;
  logic        bad_access;
  logic        accept;
  logic        do_write;
  logic [2:0]  word_sel;
  logic [31:0] read_val;

  // Apply only the enabled bytes of wdata on top of the old word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  assign tick       = (pcount == PCOUNT_LAST);
  assign word_sel   = addr[4:2];
  // Accesses outside the window belong to someone else: never acknowledged.
  assign in_window  = (addr[31:5] == BASE_ADDR[31:5]);
  assign bad_access = (addr[1:0] != 2'b00) || (word_sel > 3'd4);
  assign accept     = (state == ST_IDLE) && (ren || wen) && in_window;
  // ren and wen together is illegal; the write is honoured in that case.
  assign do_write   = accept && wen && !bad_access;

  always_comb begin
    read_val = 32'd0;
    case (word_sel)
      3'd0:    read_val = mtime[31:0];
      3'd1:    read_val = mtime[63:32];
      3'd2:    read_val = mtimecmp[31:0];
      3'd3:    read_val = mtimecmp[63:32];
      3'd4:    read_val = {31'd0, msip};
      default: read_val = 32'd0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      pcount    <= 16'd0;
      mtime     <= 64'd0;
      mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip      <= 1'b0;
      timer_int <= 1'b0;
      ack       <= 1'b0;
      error     <= 1'b0;
      rdata     <= 32'd0;
    end else begin
      // Prescaler runs free; bus writes never disturb it.
      pcount    <= tick ? 16'd0 : pcount + 16'd1;
      timer_int <= (mtime >= mtimecmp);

      // A bus write to either mtime word wins over a coincident tick,
      // which is then lost rather than applied on top of the new value.
      if (do_write && word_sel == 3'd0)
        mtime <= {mtime[63:32], merge_bytes(mtime[31:0], wdata, byte_en)};
      else if (do_write && word_sel == 3'd1)
        mtime <= {merge_bytes(mtime[63:32], wdata, byte_en), mtime[31:0]};
      else if (tick)
        mtime <= mtime + 64'd1;

      if (do_write && word_sel == 3'd2)
        mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], wdata, byte_en);
      if (do_write && word_sel == 3'd3)
        mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], wdata, byte_en);
      if (do_write && word_sel == 3'd4 && byte_en[0])
        msip <= wdata[0];

      case (state)
        ST_IDLE: begin
          ack   <= 1'b0;
          error <= 1'b0;
          rdata <= 32'd0;
          if (accept) begin
            state <= ST_ACK;
            ack   <= 1'b1;
            error <= bad_access;
            rdata <= (ren && !wen && !bad_access) ? read_val : 32'd0;
          end
        end
        ST_ACK: begin
          // Request may still be high here; it is deliberately not re-taken.
          state <= ST_IDLE;
          ack   <= 1'b0;
          error <= 1'b0;
          rdata <= 32'd0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mtime_o  = mtime;
  assign soft_int = msip;

endmodule

// File: tb/tb_machine_timer_unit.sv
// Bench for machine_timer_unit: one instance with PRESCALE=1 at the default
// base and one with PRESCALE=4 at 0x1000 share a single request bus, so each
// access also checks that the other instance ignores it.
module tb_machine_timer_unit;

  localparam logic [31:0] BASE1 = 32'hFFFF_FFE0;
  localparam logic [31:0] BASE4 = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ren, wen;
  logic [31:0] addr;
  logic [3:0]  byte_en;
  logic [31:0] wdata;

  logic [31:0] rdata1, rdata4;
  logic        ack1, ack4, error1, error4;
  logic [63:0] mtime1, mtime4;
  logic        timer1, timer4, soft1, soft4;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  string step  = "init";

  always #5 clk = ~clk;

  // Edges since reset release; the PRESCALE=4 instance ticks when cyc%4==0.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  machine_timer_unit #(.BASE_ADDR(BASE1), .PRESCALE(1)) dut1 (
    .CLK(clk), .RST(rst), .ren(ren), .wen(wen), .addr(addr),
    .byte_en(byte_en), .wdata(wdata), .rdata(rdata1), .ack(ack1),
    .error(error1), .mtime_o(mtime1), .timer_int(timer1), .soft_int(soft1)
  );

  machine_timer_unit #(.BASE_ADDR(BASE4), .PRESCALE(4)) dut4 (
    .CLK(clk), .RST(rst), .ren(ren), .wen(wen), .addr(addr),
    .byte_en(byte_en), .wdata(wdata), .rdata(rdata4), .ack(ack4),
    .error(error4), .mtime_o(mtime4), .timer_int(timer4), .soft_int(soft4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s/%s: observed=%0h expected=%0h", step, tag, got, exp);
    end
  endtask

  task automatic tick_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus access: request driven just after an edge, ack expected right
  // after the next edge, then the idle cycle with ack/error/rdata back at 0.
  task automatic access(input bit d4, input bit wr, input logic [4:0] off,
                        input logic [3:0] be, input logic [31:0] wd,
                        input bit exp_err, input logic [31:0] exp_rd);
    addr    = (d4 ? BASE4 : BASE1) + {27'd0, off};
    byte_en = be;
    wdata   = wd;
    wen     = wr;
    ren     = !wr;
    chk("ack_before", 64'(d4 ? ack4 : ack1), 64'd0);
    tick_edges(1);
    chk("ack", 64'(d4 ? ack4 : ack1), 64'd1);
    chk("other_ack", 64'(d4 ? ack1 : ack4), 64'd0);
    chk("error", 64'(d4 ? error4 : error1), 64'(exp_err));
    if (!wr || exp_err) chk("rdata", 64'(d4 ? rdata4 : rdata1), 64'(exp_rd));
    ren = 1'b0;
    wen = 1'b0;
    tick_edges(1);
    chk("ack_drop", 64'(d4 ? ack4 : ack1), 64'd0);
    chk("error_drop", 64'(d4 ? error4 : error1), 64'd0);
    chk("rdata_drop", 64'(d4 ? rdata4 : rdata1), 64'd0);
  endtask

  initial begin
    rst = 1'b1; ren = 1'b0; wen = 1'b0;
    addr = 32'd0; byte_en = 4'h0; wdata = 32'd0;

    // Reset state.
    step = "reset";
    tick_edges(3);
    chk("mtime", mtime1, 64'd0);
    chk("ack", 64'(ack1), 64'd0);
    chk("error", 64'(error1), 64'd0);
    chk("rdata", 64'(rdata1), 64'd0);
    chk("timer", 64'(timer1), 64'd0);
    chk("soft", 64'(soft1), 64'd0);
    chk("mtime4", mtime4, 64'd0);
    rst = 1'b0;

    // Free running for 10 cycles.
    step = "idle10";
    tick_edges(10);
    chk("mtime", mtime1, 64'd10);
    chk("mtime4", mtime4, 64'd2);
    chk("timer", 64'(timer1), 64'd0);
    chk("soft", 64'(soft1), 64'd0);
    access(1'b0, 1'b0, 5'h08, 4'hF, 32'd0, 1'b0, 32'hFFFF_FFFF);

    // Carry from the low word into the high word.
    step = "carry";
    access(1'b0, 1'b1, 5'h00, 4'hF, 32'hFFFF_FFFE, 1'b0, 32'd0);
    access(1'b0, 1'b1, 5'h04, 4'hF, 32'h0000_0001, 1'b0, 32'd0);
    chk("mtime", mtime1, 64'h0000_0002_0000_0000);
    tick_edges(1);
    chk("mtime_next", mtime1, 64'h0000_0002_0000_0001);

    // Compare: mtime set to 0xC, cmp written hi then lo, mtime 0x10 at cmp write.
    step = "timer";
    access(1'b0, 1'b1, 5'h04, 4'hF, 32'd0, 1'b0, 32'd0);
    access(1'b0, 1'b1, 5'h00, 4'hF, 32'h0000_000C, 1'b0, 32'd0);
    access(1'b0, 1'b1, 5'h0C, 4'hF, 32'd0, 1'b0, 32'd0);
    access(1'b0, 1'b1, 5'h08, 4'hF, 32'h0000_0020, 1'b0, 32'd0);
    chk("mtime", mtime1, 64'h11);
    chk("timer_low", 64'(timer1), 64'd0);
    tick_edges(15);
    chk("mtime_at_cmp", mtime1, 64'h20);
    chk("timer_lag", 64'(timer1), 64'd0);
    tick_edges(1);
    chk("timer_rise", 64'(timer1), 64'd1);
    tick_edges(3);
    chk("timer_hold", 64'(timer1), 64'd1);
    access(1'b0, 1'b1, 5'h0C, 4'hF, 32'h0000_0001, 1'b0, 32'd0);
    chk("timer_drop", 64'(timer1), 64'd0);

    // MSIP bit and byte enables.
    step = "msip";
    access(1'b0, 1'b1, 5'h10, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'd0);
    chk("soft_set", 64'(soft1), 64'd1);
    access(1'b0, 1'b0, 5'h10, 4'hF, 32'd0, 1'b0, 32'h0000_0001);
    access(1'b0, 1'b1, 5'h10, 4'hF, 32'd0, 1'b0, 32'd0);
    chk("soft_clr", 64'(soft1), 64'd0);
    access(1'b0, 1'b1, 5'h10, 4'b1110, 32'h0000_0001, 1'b0, 32'd0);
    chk("soft_be_keep0", 64'(soft1), 64'd0);
    access(1'b0, 1'b1, 5'h10, 4'hF, 32'h0000_0001, 1'b0, 32'd0);
    access(1'b0, 1'b1, 5'h10, 4'b1110, 32'd0, 1'b0, 32'd0);
    chk("soft_be_keep1", 64'(soft1), 64'd1);
    access(1'b0, 1'b0, 5'h10, 4'hF, 32'd0, 1'b0, 32'h0000_0001);

    // PRESCALE=4: write landing on a tick edge drops that tick.
    step = "prescale";
    chk("mtime4_model", mtime4, 64'(cyc / 4));
    while (((cyc + 1) % 4) != 0) tick_edges(1);
    access(1'b1, 1'b1, 5'h00, 4'hF, 32'h0000_0100, 1'b0, 32'd0);
    chk("mtime4_written", mtime4, 64'h100);
    tick_edges(2);
    chk("mtime4_dropped", mtime4, 64'h100);
    tick_edges(1);
    chk("mtime4_next", mtime4, 64'h101);

    // Unmapped and misaligned accesses.
    step = "errors";
    access(1'b0, 1'b0, 5'h14, 4'hF, 32'd0, 1'b1, 32'd0);
    access(1'b0, 1'b1, 5'h02, 4'hF, 32'hDEAD_BEEF, 1'b1, 32'd0);
    access(1'b0, 1'b1, 5'h0A, 4'hF, 32'd0, 1'b1, 32'd0);
    access(1'b0, 1'b1, 5'h18, 4'hF, 32'd0, 1'b1, 32'd0);
    access(1'b0, 1'b0, 5'h09, 4'hF, 32'd0, 1'b1, 32'd0);
    access(1'b0, 1'b0, 5'h08, 4'hF, 32'd0, 1'b0, 32'h0000_0020);
    access(1'b0, 1'b0, 5'h0C, 4'hF, 32'd0, 1'b0, 32'h0000_0001);
    chk("soft_kept", 64'(soft1), 64'd1);

    // Reset aborts a write request.
    step = "reset_abort";
    addr = BASE1 + 32'h8; byte_en = 4'hF; wdata = 32'h0000_1234;
    wen = 1'b1; rst = 1'b1;
    tick_edges(1);
    chk("ack", 64'(ack1), 64'd0);
    chk("mtime", mtime1, 64'd0);
    chk("soft", 64'(soft1), 64'd0);
    chk("timer", 64'(timer1), 64'd0);
    wen = 1'b0; rst = 1'b0;
    access(1'b0, 1'b0, 5'h08, 4'hF, 32'd0, 1'b0, 32'hFFFF_FFFF);
    access(1'b0, 1'b0, 5'h0C, 4'hF, 32'd0, 1'b0, 32'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/machine_timer_unit.md
# machine_timer_unit

Memory-mapped machine timer and software-interrupt source for the privileged 1.11 machine-mode CSR block. Holds the 64-bit `mtime` counter, the `mtimecmp` comparator and the `msip` bit behind a single-outstanding request/acknowledge bus slave. It drives the `mtip` and `msip` pending inputs of the `mip_t` CSR and exposes `mtime` for the `time`/`timeh` counter CSRs.

## Interface
- `BASE_ADDR`, default 32'hFFFF_FFE0: byte base of the 32-byte register window; must be 32-byte aligned.
- `PRESCALE`, default 1: `mtime` increments once every `PRESCALE` clock cycles; legal range 1..65535.
- `CLK` in 1: clock. All state is on the rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `ren` in 1: read request; held until `ack`.
- `wen` in 1: write request; held until `ack`. `ren` and `wen` together are illegal.
- `addr` in 32: byte address, word aligned.
- `byte_en` in 4: write byte enables, with bit i covering `wdata[8i+7:8i]`.
- `wdata` in 32: write data.
- `rdata` out 32: read data, valid while `ack` is high.
- `ack` out 1: one-cycle completion pulse.
- `error` out 1: qualifies `ack` and flags an unmapped or misaligned access.
- `mtime_o` out 64: current `mtime` value.
- `timer_int` out 1: drives `mip.mtip`.
- `soft_int` out 1: drives `mip.msip`.

## Operation
- Offsets from `BASE_ADDR`:
  - 0x00 `MTIME[31:0]`
  - 0x04 `MTIME[63:32]`
  - 0x08 `MTIMECMP[31:0]`
  - 0x0C `MTIMECMP[63:32]`
  - 0x10 `MSIP`: bit 0 is read/write; bits 31:1 read as 0 and ignore writes.
- Offsets 0x14–0x1C are unmapped. Any `addr[1:0]` ≠ 0 is misaligned. Both cases return `ack` with `error=1` and `rdata=0`, and no state changes.
- Addresses outside the 32-byte window are ignored: no `ack` is ever returned. This is the interconnect's responsibility.
- Writes apply only the enabled bytes; disabled bytes keep their value.
- Prescaler:
  - `pcount` counts 0..PRESCALE-1 and wraps.
  - A tick occurs in the cycle where `pcount == PRESCALE-1`.
  - With PRESCALE=1, every cycle is a tick.
- On a tick, `mtime <= mtime + 1` as a full 64-bit add. The carry propagates from low to high. `0xFFFF_FFFF_FFFF_FFFF` wraps to 0.
- Write/tick collision:
  - A bus write to either `MTIME` word in the same cycle as a tick wins. The whole 64-bit `mtime` takes the written value, with the other word unchanged, and that tick is dropped.
  - `pcount` is not disturbed by bus writes.
- `timer_int` is registered: `mtime >= mtimecmp`, an unsigned 64-bit compare on the current registered values.
- `soft_int` equals the `MSIP` bit 0 register.
- Reads return register values as of the cycle the request is accepted.

## Timing
- Reset values, one cycle after `RST` is sampled high:
  - `mtime=0`, `pcount=0`
  - `mtimecmp=64'hFFFF_FFFF_FFFF_FFFF`
  - `MSIP=0`
  - `ack=0`, `error=0`, `rdata=0`
  - `timer_int=0`, `soft_int=0`
- Bus FSM states:
  - IDLE: when `ren|wen` is seen, accept, perform the write or capture the read data, and go to ACK.
  - ACK: drive `ack=1` (and `error`/`rdata`) for exactly one cycle, then return to IDLE.
  - A request still held high during ACK is not re-accepted. The master must drop it in the `ack` cycle.
  - Throughput: one access per 2 cycles.
- Latency: request at edge N, `ack` at edge N+1. A write takes effect at edge N+1, the same edge `ack` rises.
- `timer_int` lags its compare inputs by one cycle. After a `mtimecmp` write at edge N, `timer_int` reflects the new value at edge N+1.
- `RST` mid-transaction aborts it: no `ack` is issued and any pending write is discarded.
- `rdata` and `error` return to 0 whenever `ack=0`.

## Test plan
- Reset, then idle 10 cycles with PRESCALE=1 → `mtime_o=10`, `timer_int=0`, `soft_int=0`; a read of 0x08 returns 0xFFFF_FFFF with `ack` one cycle after the request.
- Write `MTIME[31:0]=0xFFFF_FFFE` and `MTIME[63:32]=0x0000_0001` → two ticks later `mtime_o=0x0000_0002_0000_0000` (carry into the high word).
- Write `MTIMECMP=0x0000_0000_0000_0020` (high word first) with `mtime` at 0x10 → `timer_int` rises one cycle after `mtime` reaches 0x20 and stays high; writing `MTIMECMP[63:32]=1` drops it on the next cycle.
- Write `MSIP` with `wdata=0xFFFF_FFFF` → `soft_int=1` and `MSIP` reads back 0x0000_0001; write 0 → `soft_int=0`; a `byte_en=4'b1110` write of 1 leaves the bit unchanged.
- PRESCALE=4: a write of `MTIME[31:0]=0x100` in a tick cycle → `mtime=0x100` and that tick is dropped; the next tick, 4 cycles later, gives 0x101.
- Read 0x14 and a write to 0x02 → `ack=1`, `error=1`, `rdata=0`, no register changes; `RST` asserted in the cycle after a write request → no `ack`, target register at its reset value.
